// File: rtl/alien_mover.sv
// alien_mover: turns accepted motion commands into pixel-by-pixel moves of the
// alien position registers. Drives the canLeft/canRight boundary flags sampled
// by the zig-zag controller, and sets a sticky landed flag at the bottom limit.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   enable, motion   command strobe and 3-bit command (001 L, 010 R, 100 D)
//   x, y             10-bit alien position
//   canLeft/Right    a left/right command would be accepted now (combinational)
//   busy             a move is in progress
//   landed           alien reached Y_MAX; cleared only by reset
module alien_mover #(
  parameter int unsigned X_MIN  = 0,
  parameter int unsigned X_MAX  = 600,
  parameter int unsigned Y_MAX  = 448,
  parameter int unsigned X_INIT = 304,
  parameter int unsigned Y_INIT = 32,
  parameter int unsigned STEP_X = 8,
  parameter int unsigned STEP_Y = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] motion,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       canLeft,
  output logic       canRight,
  output logic       busy,
  output logic       landed
);

  localparam int unsigned PW = 10;  // position / counter width
  localparam int unsigned CW = 11;  // boundary compare width, avoids wrap

  localparam logic [2:0] CMD_LEFT  = 3'b001;
  localparam logic [2:0] CMD_RIGHT = 3'b010;
  localparam logic [2:0] CMD_DOWN  = 3'b100;

  typedef enum logic [1:0] {IDLE, MOVE, LANDED} state_t;
  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_DOWN} dir_t;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [PW-1:0] x_q, x_d;
  logic [PW-1:0] y_q, y_d;
  logic          can_left_c, can_right_c;

  // Boundary flags: only meaningful while waiting for a command
  assign can_left_c  = (state_q == IDLE) &&
                       (CW'(x_q) >= CW'(X_MIN) + CW'(STEP_X));
  assign can_right_c = (state_q == IDLE) &&
                       (CW'(x_q) + CW'(STEP_X) <= CW'(X_MAX));

  // State and position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_LEFT;
      rem_q   <= '0;
      x_q     <= PW'(X_INIT);
      y_q     <= PW'(Y_INIT);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Command acceptance and one-pixel-per-cycle stepping
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          case (motion)
            CMD_LEFT: begin
              if (can_left_c) begin
                dir_d   = DIR_LEFT;
                rem_d   = PW'(STEP_X);
                state_d = MOVE;
              end
            end
            CMD_RIGHT: begin
              if (can_right_c) begin
                dir_d   = DIR_RIGHT;
                rem_d   = PW'(STEP_X);
                state_d = MOVE;
              end
            end
            CMD_DOWN: begin
              dir_d   = DIR_DOWN;
              rem_d   = PW'(STEP_Y);
              state_d = MOVE;
            end
            default: ;
          endcase
        end
      end
      MOVE: begin
        rem_d = rem_q - PW'(1);
        case (dir_q)
          DIR_LEFT:  x_d = x_q - PW'(1);
          DIR_RIGHT: x_d = x_q + PW'(1);
          DIR_DOWN:  y_d = y_q + PW'(1);
          default:   ;
        endcase
        // Last pixel of the move: landing is judged on the updated y
        if (rem_q == PW'(1)) begin
          if ((dir_q == DIR_DOWN) && (CW'(y_d) >= CW'(Y_MAX))) begin
            state_d = LANDED;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LANDED:  ;
      default: state_d = IDLE;
    endcase
  end

  assign x        = x_q;
  assign y        = y_q;
  assign canLeft  = can_left_c;
  assign canRight = can_right_c;
  assign busy     = (state_q == MOVE);
  assign landed   = (state_q == LANDED);

endmodule
